// File: rtl/baud_gen_prog_if.sv
// rtl/baud_gen_prog_if.sv - control and strobe bundle for the programmable bit-rate generator
interface baud_gen_prog_if #(
    parameter int CNT_W = 16
);
    logic             bps_start;
    logic             div_wr;
    logic [CNT_W-1:0] div_in;
    logic             clk_bps;
    logic             bit_end;
    logic [CNT_W-1:0] div_cur;
    logic             div_pend;
    logic             div_err;
    logic             ovs_tick;

    modport master (
        output bps_start, div_wr, div_in,
        input  clk_bps, bit_end, div_cur, div_pend, div_err, ovs_tick
    );

    modport slave (
        input  bps_start, div_wr, div_in,
        output clk_bps, bit_end, div_cur, div_pend, div_err, ovs_tick
    );
endinterface

// File: rtl/baud_gen_prog.sv
// rtl/baud_gen_prog.sv - run-time programmable UART bit-rate generator (optional oversample tick: BAUD_OVS_EN)
module baud_gen_prog #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 5207,
    parameter int DIV_MIN     = 3
`ifdef BAUD_OVS_EN
    ,
    parameter int OVS_LOG2    = 4
`endif
) (
    input  logic            sys_clk,
    input  logic            sys_rstn,
    baud_gen_prog_if.slave  bus
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_cur_q;
    logic [CNT_W-1:0] pend_val;
    logic             pend_q;
    logic             clk_bps_q;
    logic             bit_end_q;
    logic             div_err_q;

    logic [CNT_W-1:0] half;
    logic             wrap;
    logic             wr_ok;
    logic             wr_bad;

    // The wrap compare always uses the divisor in force, so a bit in flight keeps its length
    assign half   = div_cur_q >> 1;
    assign wrap   = bus.bps_start && (cnt == div_cur_q);
    assign wr_ok  = bus.div_wr && (bus.div_in >= DIV_LO);
    assign wr_bad = bus.div_wr && (bus.div_in < DIV_LO);

    // Bit counter: held at 0 while stopped, wraps after div_cur
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            cnt <= '0;
        end else if (!bus.bps_start || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered mid-bit, end-of-bit and rejected-write strobes
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            clk_bps_q <= 1'b0;
            bit_end_q <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            clk_bps_q <= bus.bps_start && (cnt == half);
            bit_end_q <= wrap;
            div_err_q <= wr_bad;
        end
    end

    // Divisor update: immediate when stopped or on a wrap, otherwise parked until the next wrap
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            div_cur_q <= DIV_RST;
            pend_val  <= '0;
            pend_q    <= 1'b0;
        end else if (wr_ok) begin
            if (!bus.bps_start || wrap) begin
                div_cur_q <= bus.div_in;
                pend_q    <= 1'b0;
            end else begin
                pend_val  <= bus.div_in;
                pend_q    <= 1'b1;
            end
        end else if (pend_q && (!bus.bps_start || wrap)) begin
            div_cur_q <= pend_val;
            pend_q    <= 1'b0;
        end
    end

    assign bus.clk_bps  = clk_bps_q;
    assign bus.bit_end  = bit_end_q;
    assign bus.div_cur  = div_cur_q;
    assign bus.div_pend = pend_q;
    assign bus.div_err  = div_err_q;

`ifdef BAUD_OVS_EN
    logic [CNT_W-1:0] ocnt;
    logic [CNT_W-1:0] ovs_p;
    logic             ovs_last;
    logic             ovs_tick_q;

    // Prescale never drops below 1 so very small divisors still tick every cycle
    assign ovs_p    = ((div_cur_q >> OVS_LOG2) == '0) ? CNT_W'(1) : (div_cur_q >> OVS_LOG2);
    assign ovs_last = (ocnt == ovs_p - CNT_W'(1));

    // Oversample counter, realigned to the start of every bit
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            ocnt       <= '0;
            ovs_tick_q <= 1'b0;
        end else begin
            ovs_tick_q <= bus.bps_start && ovs_last;
            if (!bus.bps_start || wrap || ovs_last) begin
                ocnt <= '0;
            end else begin
                ocnt <= ocnt + CNT_W'(1);
            end
        end
    end

    assign bus.ovs_tick = ovs_tick_q;
`else
    assign bus.ovs_tick = 1'b0;
`endif
endmodule

// File: tb/tb_baud_gen_prog.sv
// tb/tb_baud_gen_prog.sv - randomized self-checking bench for baud_gen_prog
module tb_baud_gen_prog;
    localparam int DEF = 5207;
    localparam int DMIN = 3;

    logic sys_clk = 1'b0;
    logic sys_rstn = 1'b0;

    baud_gen_prog_if #(.CNT_W(16)) bif ();

    baud_gen_prog dut (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .bus      (bif.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: tracks where the current bit started in edge numbers
    int   m_n = 0;
    int   m_bs = 0;
    bit   m_run = 0;
    int   m_div = DEF;
    bit   m_pend = 0;
    int   m_pval = 0;
    bit   e_bps, e_end, e_err, e_ovs;

    int   k = -1;
    int   q_bps[$];
    int   q_end[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    function automatic void model_edge(input bit rn, input bit st, input bit wr, input int din);
        int pos;
        int p;
        bit wrap;
        e_bps = 0; e_end = 0; e_err = 0; e_ovs = 0; wrap = 0;
        if (!rn) begin
            m_div = DEF; m_pend = 0; m_run = 0;
        end else begin
            if (st) begin
                if (!m_run) begin
                    m_bs = m_n;
                    m_run = 1;
                end
                pos   = m_n - m_bs;
                e_bps = (pos == m_div / 2);
                e_end = (pos == m_div);
                wrap  = e_end;
                p     = (m_div / 16 < 1) ? 1 : m_div / 16;
`ifdef BAUD_OVS_EN
                e_ovs = (pos % p == p - 1);
`else
                e_ovs = (p < 0);
`endif
            end
            e_err = wr && (din < DMIN);
            if (wr && !e_err) begin
                if (!st || wrap) begin
                    m_div = din; m_pend = 0;
                end else begin
                    m_pval = din; m_pend = 1;
                end
            end else if (m_pend && (!st || wrap)) begin
                m_div = m_pval; m_pend = 0;
            end
            if (wrap) m_bs = m_n + 1;
            if (!st) m_run = 0;
        end
        m_n++;
    endfunction

    task automatic step(input bit rn, input bit st, input bit wr, input int din);
        sys_rstn      = rn;
        bif.bps_start = st;
        bif.div_wr    = wr;
        bif.div_in    = din[15:0];
        k = (rn && st) ? k + 1 : -1;
        @(posedge sys_clk);
        model_edge(rn, st, wr, din);
        @(negedge sys_clk);
        check("clk_bps", {31'd0, bif.clk_bps}, {31'd0, e_bps});
        check("bit_end", {31'd0, bif.bit_end}, {31'd0, e_end});
        check("div_err", {31'd0, bif.div_err}, {31'd0, e_err});
        check("div_pend", {31'd0, bif.div_pend}, {31'd0, m_pend});
        check("div_cur", {16'd0, bif.div_cur}, m_div);
        check("ovs_tick", {31'd0, bif.ovs_tick}, {31'd0, e_ovs});
        if (bif.clk_bps) q_bps.push_back(k);
        if (bif.bit_end) q_end.push_back(k);
    endtask

    task automatic run(input int cycles, input bit st);
        for (int i = 0; i < cycles; i++) step(1, st, 0, 0);
    endtask

    bit st_r;
    bit rn_r;
    bit wr_r;

    initial begin
        bif.bps_start = 0;
        bif.div_wr    = 0;
        bif.div_in    = '0;

        // Reset held with bps_start high, then free run at the default divisor
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        q_bps.delete(); q_end.delete();
        run(5300, 1);
        check("rst_first_bps", qat(q_bps, 0), 2603);
        check("rst_first_end", qat(q_end, 0), 5207);

        // Idle load of divisor 9
        run(2, 0);
        step(1, 0, 1, 9);
        check("idle_load_div", {16'd0, bif.div_cur}, 9);
        run(2, 0);
        q_bps.delete(); q_end.delete();
        run(30, 1);
        check("idle_bps0", qat(q_bps, 0), 4);
        check("idle_bps1", qat(q_bps, 1), 14);
        check("idle_bps2", qat(q_bps, 2), 24);
        check("idle_end0", qat(q_end, 0), 9);
        check("idle_end1", qat(q_end, 1), 19);

        // Run-time change to 19 written while cnt==3
        run(2, 0);
        q_bps.delete(); q_end.delete();
        run(3, 1);
        step(1, 1, 1, 19);
        check("rt_pend_set", {31'd0, bif.div_pend}, 1);
        run(40, 1);
        check("rt_end0", qat(q_end, 0), 9);
        check("rt_end1", qat(q_end, 1), 29);

        // Rejected write while running at 19
        step(1, 1, 1, 2);
        check("rej_div_cur", {16'd0, bif.div_cur}, 19);
        run(60, 1);

        // Abort at cnt==6 with divisor 9, then restart
        run(2, 0);
        step(1, 0, 1, 9);
        q_bps.delete(); q_end.delete();
        run(6, 1);
        run(4, 0);
        check("abort_no_end", q_end.size(), 0);
        q_bps.delete(); q_end.delete();
        run(12, 1);
        check("restart_bps", qat(q_bps, 0), 4);

        // Divisor 159 for the oversample tick
        run(2, 0);
        step(1, 0, 1, 159);
        run(500, 1);

        // Randomized mix of writes, start toggles and occasional resets
        st_r = 1;
        for (int i = 0; i < 6000; i++) begin
            rn_r = ($urandom_range(0, 999) != 0);
            if (!rn_r) st_r = 0;
            else if ($urandom_range(0, 59) == 0) st_r = ~st_r;
            wr_r = ($urandom_range(0, 7) == 0);
            step(rn_r, st_r, wr_r, int'($urandom_range(0, 24)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
